// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Holds the arbiter state enum, the request bundle and the dmem size.
package mem_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic        be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int DMEM_WORDS = 64;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port dmem between the CPU data port
// (requester 0) and the loader/DMA engine (requester 1), with bounded locks.
// Ports:
//   clk, reset            clock, async active-high reset
//   reqN/weN/beN          request, write enable, byte write per requester
//   addrN/wdataN/lockN    byte address, write data, hold-grant request
//   ackN                  combinational grant (access on dmem this cycle)
//   rvalidN/rdataN        registered read response, one cycle after ack
//   mem_we/mem_byte_enable/mem_a/mem_wd   muxed request to dmem
//   mem_rd                combinational read data from dmem
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        be0,
    input  logic        be1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        ack0,
    output logic        ack1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_we,
    output logic        mem_byte_enable,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t  fsm_q, fsm_d;
    logic        last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        rvalid0_q, rvalid1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        gnt0, gnt1, gnt, lock_g;
    mem_req_t    r0, r1, sel;

    assign r0 = '{we: we0, be: be0, addr: addr0, wdata: wdata0};
    assign r1 = '{we: we1, be: be1, addr: addr1, wdata: wdata1};

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        fsm_d   = ARB;
        cnt_d   = '0;
        last_d  = last_q;
        sel     = '0;
        unique case (fsm_q)
            ARB: begin
                // last_q=1 means requester 0 wins a contested cycle
                if (req0 && (!req1 || last_q)) gnt0 = 1'b1;
                else if (req1)                  gnt1 = 1'b1;
            end
            HOLD0:   gnt0 = req0;
            HOLD1:   gnt1 = req1;
            default: ;
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
        gnt     = gnt0 | gnt1;
        lock_g  = gnt1 ? lock1 : lock0;
        cnt_inc = (fsm_q == ARB) ? CW'(1) : cnt_q + CW'(1);
        if (gnt) begin
            sel    = gnt1 ? r1 : r0;
            last_d = gnt1;
            if (lock_g && (cnt_inc < CW'(LOCK_MAX))) begin
                fsm_d = gnt1 ? HOLD1 : HOLD0;
                cnt_d = cnt_inc;
            end
        end
    end

    assign ack0            = gnt0;
    assign ack1            = gnt1;
    assign mem_we          = sel.we;
    assign mem_byte_enable = sel.be;
    assign mem_a           = sel.addr;
    assign mem_wd          = sel.wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= ARB;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            fsm_q     <= fsm_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0_q <= mem_rd;
            if (gnt1 && !we1) rdata1_q <= mem_rd;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table plus hand-written
// sequences for write/read, byte write, lock expiry, release and reset.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, be0, be1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we, mem_byte_enable;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .ack0(ack0), .ack1(ack1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_byte_enable(mem_byte_enable),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // dmem model: 64 words, byte lane 0 is the most significant byte
    logic [31:0] mem [64] = '{default: 32'h0};
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            if (!mem_byte_enable) mem[mem_a[7:2]] <= mem_wd;
            else case (mem_a[1:0])
                2'd0: mem[mem_a[7:2]][31:24] <= mem_wd[7:0];
                2'd1: mem[mem_a[7:2]][23:16] <= mem_wd[7:0];
                2'd2: mem[mem_a[7:2]][15:8]  <= mem_wd[7:0];
                default: mem[mem_a[7:2]][7:0] <= mem_wd[7:0];
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; be0 = 0; be1 = 0;
        lock0 = 0; lock1 = 0; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1;
        logic        ea0, ea1, ewe;
        logic [31:0] ea;
        logic        erv0, erv1;
    } vec_t;

    vec_t tv[11];

    initial begin
        logic [31:0] ewd;

        // reset dominates a pending write request
        idle();
        reset = 1; req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h55;
        @(negedge clk);
        check("rst_ack0", {31'b0, ack0}, 0);
        check("rst_mem_we", {31'b0, mem_we}, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_rvalid0", {31'b0, rvalid0}, 0);
        check("rst_rdata0", rdata0, 0);
        step();
        reset = 0;
        @(negedge clk);
        check("rel_ack0", {31'b0, ack0}, 1);
        check("rel_mem_we", {31'b0, mem_we}, 1);

        // arbitration table
        tv[0]  = '{1,1,0,1, 32'h40,32'h80, 1,0,0, 32'h40, 0,0};
        tv[1]  = '{1,1,0,1, 32'h44,32'h84, 0,1,1, 32'h84, 1,0};
        tv[2]  = '{1,1,1,0, 32'h48,32'h88, 1,0,1, 32'h48, 0,0};
        tv[3]  = '{1,1,1,0, 32'h4C,32'h8C, 0,1,0, 32'h8C, 0,0};
        tv[4]  = '{0,0,0,0, 32'h4C,32'h8C, 0,0,0, 32'h00, 0,1};
        tv[5]  = '{0,1,0,0, 32'h4C,32'h90, 0,1,0, 32'h90, 0,0};
        tv[6]  = '{0,1,0,0, 32'h4C,32'h94, 0,1,0, 32'h94, 0,1};
        tv[7]  = '{1,1,0,0, 32'h50,32'h98, 1,0,0, 32'h50, 0,1};
        tv[8]  = '{1,0,0,0, 32'h54,32'h98, 1,0,0, 32'h54, 1,0};
        tv[9]  = '{1,1,0,0, 32'h58,32'h9C, 0,1,0, 32'h9C, 1,0};
        tv[10] = '{0,0,0,0, 32'h58,32'h9C, 0,0,0, 32'h00, 0,1};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step();
            req0 = tv[i].r0; req1 = tv[i].r1;
            we0 = tv[i].w0;  we1 = tv[i].w1;
            addr0 = tv[i].a0; addr1 = tv[i].a1;
            wdata0 = {16'hA0A0, tv[i].a0[15:0]};
            wdata1 = {16'hB1B1, tv[i].a1[15:0]};
            ewd = tv[i].ea1 ? wdata1 : (tv[i].ea0 ? wdata0 : 32'h0);
            @(negedge clk);
            check($sformatf("v%0d_ack0", i), {31'b0, ack0}, {31'b0, tv[i].ea0});
            check($sformatf("v%0d_ack1", i), {31'b0, ack1}, {31'b0, tv[i].ea1});
            check($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, tv[i].ewe});
            check($sformatf("v%0d_a", i), mem_a, tv[i].ea);
            check($sformatf("v%0d_wd", i), mem_wd, ewd);
            check($sformatf("v%0d_rv0", i), {31'b0, rvalid0}, {31'b0, tv[i].erv0});
            check($sformatf("v%0d_rv1", i), {31'b0, rvalid1}, {31'b0, tv[i].erv1});
        end

        // word write then read by requester 0
        do_reset();
        step();
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_ack0", {31'b0, ack0}, 1);
        check("wr_mem_wd", mem_wd, 32'hDEADBEEF);
        step();
        we0 = 0;
        @(negedge clk);
        check("rd_ack0", {31'b0, ack0}, 1);
        check("rd_rvalid0_early", {31'b0, rvalid0}, 0);
        step();
        idle();
        @(negedge clk);
        check("rd_rvalid0", {31'b0, rvalid0}, 1);
        check("rd_rdata0", rdata0, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("rd_rvalid0_drop", {31'b0, rvalid0}, 0);
        check("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

        // byte write by requester 1
        step();
        req1 = 1; we1 = 1; addr1 = 32'h10; wdata1 = 32'h11223344;
        step();
        be1 = 1; addr1 = 32'h11; wdata1 = 32'h000000AA;
        @(negedge clk);
        check("bw_ack1", {31'b0, ack1}, 1);
        check("bw_be", {31'b0, mem_byte_enable}, 1);
        check("bw_mem_a", mem_a, 32'h11);
        step();
        be1 = 0; we1 = 0; addr1 = 32'h10;
        step();
        idle();
        @(negedge clk);
        check("bw_rvalid1", {31'b0, rvalid1}, 1);
        check("bw_rdata1", rdata1, 32'h11AA3344);

        // lock expiry at LOCK_MAX=4
        do_reset();
        step();
        req1 = 1; lock1 = 1; addr1 = 32'h30;
        @(negedge clk);
        check("lk_c1_ack1", {31'b0, ack1}, 1);
        for (int c = 2; c <= 4; c++) begin
            step();
            req0 = 1; addr0 = 32'h34;
            @(negedge clk);
            check($sformatf("lk_c%0d_ack1", c), {31'b0, ack1}, 1);
            check($sformatf("lk_c%0d_ack0", c), {31'b0, ack0}, 0);
        end
        step();
        @(negedge clk);
        check("lk_exp_ack0", {31'b0, ack0}, 1);
        check("lk_exp_ack1", {31'b0, ack1}, 0);

        // early lock release
        do_reset();
        step();
        req1 = 1; lock1 = 1;
        @(negedge clk);
        check("er_c1_ack1", {31'b0, ack1}, 1);
        step();
        req0 = 1; lock1 = 0;
        @(negedge clk);
        check("er_c2_ack1", {31'b0, ack1}, 1);
        step();
        @(negedge clk);
        check("er_c3_ack0", {31'b0, ack0}, 1);
        check("er_c3_ack1", {31'b0, ack1}, 0);

        // reset in the middle of a hold
        do_reset();
        step();
        req1 = 1; lock1 = 1; addr1 = 32'h10;
        step();
        req0 = 1;
        @(negedge clk);
        check("rh_hold_ack1", {31'b0, ack1}, 1);
        step();
        reset = 1;
        @(negedge clk);
        check("rh_rvalid1", {31'b0, rvalid1}, 0);
        check("rh_ack1", {31'b0, ack1}, 0);
        check("rh_mem_a", mem_a, 0);
        step();
        reset = 0;
        @(negedge clk);
        check("rh_after_ack0", {31'b0, ack0}, 1);
        check("rh_after_ack1", {31'b0, ack1}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (`dmem`) between requester 0 (processor data port) and requester 1 (loader/DMA engine). It grants at most one access per cycle using round-robin priority, supports a bounded lock for burst transfers by either requester, and returns read data through a registered response path. It sits directly in front of `dmem`; `dmem` itself is unchanged.

## Interface
- `LOCK_MAX`, 16, maximum consecutive granted cycles a locking requester may hold; must be ≥ 1.
- `clk` in 1: single clock; dmem shares it.
- `reset` in 1: asynchronous, active-high.
- `req0`, `req1` in 1: access request; held until acked.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `be0`, `be1` in 1: byte write; lane `addr[1:0]`, data `wdata[7:0]`.
- `addr0`, `addr1` in 32: byte address.
- `wdata0`, `wdata1` in 32: write data.
- `lock0`, `lock1` in 1: request to keep the grant after this access.
- `ack0`, `ack1` out 1: combinational; access presented to dmem this cycle.
- `rvalid0`, `rvalid1` out 1: registered; read data valid.
- `rdata0`, `rdata1` out 32: registered read data.
- `mem_we`, `mem_byte_enable` out 1: to dmem `we` and `byte_enable`.
- `mem_a`, `mem_wd` out 32: to dmem `a` and `wd`.
- `mem_rd` in 32: from dmem `rd`, which is combinational.

## Operation
- State: `fsm` ∈ {ARB, HOLD0, HOLD1}; `last` (1 bit) holds the last granted index; `cnt` holds the count of granted cycles in the current hold.
- **ARB:**
  - If only one requester requests, grant it.
  - If both request, grant `!last`.
  - No request: no grant, all mem outputs held at 0.
- **HOLDi:**
  - Only requester i is eligible; the other is never acked.
  - If `req_i`=0: no grant, next state ARB.
- **Grant effects (both states):**
  - `ack_i`=1 and `last`←i.
  - Mem ports are muxed from requester i: `mem_we`=`we_i`, `mem_byte_enable`=`be_i`, `mem_a`=`addr_i`, `mem_wd`=`wdata_i`.
  - Address and data pass through unmodified.
- **Lock accounting:**
  - On a grant from ARB with `lock_i`=1: `cnt`←1, next state HOLDi.
  - On a grant in HOLDi: `cnt`←`cnt`+1.
  - Stay in HOLDi only if `lock_i`=1 and the new `cnt` < `LOCK_MAX`; otherwise go to ARB.
  - On expiry, `last`=i, so the other requester wins the next contested cycle.
  - With `LOCK_MAX`=1, no hold is ever entered.
- **Reads:** on a granted read (`we_i`=0), `rdata_i`←`mem_rd` and `rvalid_i`←1 at the clock edge; otherwise `rvalid_i`←0. `rdata_i` holds its value when not updated.
- **Writes:** dmem commits at the edge ending the ack cycle; no rvalid.
- A requester may present a new request in the cycle after its ack; back-to-back grants to the same requester are allowed.

## Timing
- **Reset values:**
  - State: `fsm`=ARB, `last`=1 (requester 0 wins the first contest), `cnt`=0.
  - Registered outputs: `rvalid0/1`=0, `rdata0/1`=0.
  - While `reset` is high: `ack0/1`=0 and all `mem_*`=0, forced combinationally.
- **Latency:**
  - Ack is in the request cycle when granted.
  - Read data arrives exactly 1 cycle after ack.
  - Write takes effect at the ack-cycle edge.
- **Throughput:** one access per cycle total.
- **Reset mid-hold:** immediate return to ARB; pending rvalid is cleared; an un-acked request must be re-presented.
- Simultaneous read-after-write to the same address is not possible (one access per cycle). A read in the cycle after a write returns the new data.

## Structure
- Shared package `mem_pkg` holds:
  - `arb_state_t` enum {ARB, HOLD0, HOLD1};
  - a `mem_req_t` struct {we, be, addr, wdata} used for the request mux;
  - constant `DMEM_WORDS`=64.
- No sub-module needed. Grant logic is one `always_comb`; state and response registers are one `always_ff` with async reset.

## Test plan
- **Reset:** assert `reset` with `req0`=1 → `ack0`=0, `mem_we`=0, `rvalid0`=0; release → `ack0`=1 in the same cycle.
- **Contention:** `req0`=`req1`=1 continuously, no locks → acks alternate 0,1,0,1 starting with 0.
- **Write then read:** req0 word write 0xDEADBEEF @0x10, next cycle req0 read @0x10 → `rvalid0`=1, `rdata0`=0xDEADBEEF one cycle after the read ack.
- **Byte write:** req1 `be1`=1, addr 0x11, wdata 0x000000AA over 0x11223344 → read @0x10 returns 0x11AA3344.
- **Lock expiry:** `LOCK_MAX`=4, req1+`lock1` held, `req0` held → four consecutive `ack1`, then `ack0`, with `ack0`=0 throughout the hold.
- **Early lock release:** req1+`lock1`, with `lock1` dropped on its second access and `req0` waiting → the next cycle acks requester 0.
